// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the MEM stage and the debug port.
package dmem_arb_pkg;

    typedef enum logic {
        CPU_PRI = 1'b0,
        DBG_PRI = 1'b1
    } arbState_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_CPU  = 2'b01,
        SEL_DBG  = 2'b10
    } portSel_e;

    localparam logic [2:0] FUNC3_WORD = 3'b010;
    localparam int         WAIT_W     = 4;
    localparam logic [WAIT_W-1:0] WAIT_SAT = 4'hF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the arbiter: CPU requester, debug requester and the shared memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpuReq_I;
    logic              cpuWe_I;
    logic [ADDR_W-1:0] cpuAddr_I;
    logic [DATA_W-1:0] cpuWrData_I;
    logic [2:0]        cpuFunc3_I;
    logic              cpuGnt_O;
    logic              cpuStall_O;
    logic [DATA_W-1:0] cpuRdData_O;
    logic              cpuRdValid_O;

    logic              dbgReq_I;
    logic              dbgWe_I;
    logic [ADDR_W-1:0] dbgAddr_I;
    logic [DATA_W-1:0] dbgWrData_I;
    logic              dbgGnt_O;
    logic [DATA_W-1:0] dbgRdData_O;
    logic              dbgRdValid_O;

    logic [ADDR_W-1:0] memAddr_O;
    logic [DATA_W-1:0] memWrData_O;
    logic [2:0]        memFunc3_O;
    logic              memWriteEn_O;
    logic              memReadEnable_O;
    logic [DATA_W-1:0] memRdData_I;

    modport slave (
        input  cpuReq_I, cpuWe_I, cpuAddr_I, cpuWrData_I, cpuFunc3_I,
        input  dbgReq_I, dbgWe_I, dbgAddr_I, dbgWrData_I, memRdData_I,
        output cpuGnt_O, cpuStall_O, cpuRdData_O, cpuRdValid_O,
        output dbgGnt_O, dbgRdData_O, dbgRdValid_O,
        output memAddr_O, memWrData_O, memFunc3_O, memWriteEn_O, memReadEnable_O
    );

    modport master (
        output cpuReq_I, cpuWe_I, cpuAddr_I, cpuWrData_I, cpuFunc3_I,
        output dbgReq_I, dbgWe_I, dbgAddr_I, dbgWrData_I, memRdData_I,
        input  cpuGnt_O, cpuStall_O, cpuRdData_O, cpuRdValid_O,
        input  dbgGnt_O, dbgRdData_O, dbgRdValid_O,
        input  memAddr_O, memWrData_O, memFunc3_O, memWriteEn_O, memReadEnable_O
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Cycle-by-cycle arbiter for the single-port data memory: CPU wins conflicts until the
// debug port has lost MAX_WAIT consecutive cycles, then debug wins once.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_I,
    input  logic          reset_I,
    dmem_arbiter_if.slave bus
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arbState_e         state_r;
    arbState_e         nextState_s;
    logic [WAIT_W-1:0] waitCnt_r;
    logic              cpuGnt_s;
    logic              dbgGnt_s;
    logic              dbgLose_s;
    portSel_e          sel_s;
    logic [DATA_W-1:0] cpuRdData_r;
    logic [DATA_W-1:0] dbgRdData_r;
    logic              cpuRdValid_r;
    logic              dbgRdValid_r;

    // Arbitration state register.
    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            state_r <= CPU_PRI;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic: debug gets priority for exactly one cycle after starving.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            CPU_PRI: begin
                if (dbgLose_s && (waitCnt_r == WAIT_LAST)) begin
                    nextState_s = DBG_PRI;
                end else begin
                    nextState_s = CPU_PRI;
                end
            end
            DBG_PRI: begin
                if (dbgGnt_s || !bus.dbgReq_I) begin
                    nextState_s = CPU_PRI;
                end else begin
                    nextState_s = DBG_PRI;
                end
            end
            default: nextState_s = CPU_PRI;
        endcase
    end

    // Grant decode; grants are held low for as long as reset is asserted.
    always_comb begin
        cpuGnt_s = 1'b0;
        dbgGnt_s = 1'b0;
        if (!reset_I) begin
            cpuGnt_s = 1'b0;
            dbgGnt_s = 1'b0;
        end else begin
            case (state_r)
                CPU_PRI: dbgGnt_s = bus.dbgReq_I & ~bus.cpuReq_I;
                DBG_PRI: dbgGnt_s = bus.dbgReq_I;
                default: dbgGnt_s = 1'b0;
            endcase
            cpuGnt_s = bus.cpuReq_I & ~dbgGnt_s;
        end
    end

    assign dbgLose_s = bus.dbgReq_I & ~dbgGnt_s;

    // Winner select shared by the memory mux and the read-return capture.
    always_comb begin
        sel_s = SEL_NONE;
        case ({cpuGnt_s, dbgGnt_s})
            2'b10:   sel_s = SEL_CPU;
            2'b01:   sel_s = SEL_DBG;
            default: sel_s = SEL_NONE;
        endcase
    end

    // Memory-side mux; everything reads as zero when nobody is granted.
    always_comb begin
        bus.memAddr_O       = {ADDR_W{1'b0}};
        bus.memWrData_O     = {DATA_W{1'b0}};
        bus.memFunc3_O      = 3'b000;
        bus.memWriteEn_O    = 1'b0;
        bus.memReadEnable_O = 1'b0;
        case (sel_s)
            SEL_CPU: begin
                bus.memAddr_O       = bus.cpuAddr_I;
                bus.memWrData_O     = bus.cpuWrData_I;
                bus.memFunc3_O      = bus.cpuFunc3_I;
                bus.memWriteEn_O    = bus.cpuWe_I;
                bus.memReadEnable_O = ~bus.cpuWe_I;
            end
            SEL_DBG: begin
                bus.memAddr_O       = bus.dbgAddr_I;
                bus.memWrData_O     = bus.dbgWrData_I;
                bus.memFunc3_O      = FUNC3_WORD;
                bus.memWriteEn_O    = bus.dbgWe_I;
                bus.memReadEnable_O = ~bus.dbgWe_I;
            end
            default: begin
                bus.memAddr_O       = {ADDR_W{1'b0}};
                bus.memWrData_O     = {DATA_W{1'b0}};
                bus.memFunc3_O      = 3'b000;
                bus.memWriteEn_O    = 1'b0;
                bus.memReadEnable_O = 1'b0;
            end
        endcase
    end

    // Starvation counter: clears whenever debug is served, idle, or priority falls back.
    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            waitCnt_r <= {WAIT_W{1'b0}};
        end else if (dbgGnt_s || !bus.dbgReq_I ||
                     ((state_r == DBG_PRI) && (nextState_s == CPU_PRI))) begin
            waitCnt_r <= {WAIT_W{1'b0}};
        end else if (dbgLose_s && (waitCnt_r != WAIT_SAT)) begin
            waitCnt_r <= waitCnt_r + 4'd1;
        end else begin
            waitCnt_r <= waitCnt_r;
        end
    end

    // Read return: capture on the winner's read grant, pulse valid the next cycle.
    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            cpuRdData_r  <= {DATA_W{1'b0}};
            dbgRdData_r  <= {DATA_W{1'b0}};
            cpuRdValid_r <= 1'b0;
            dbgRdValid_r <= 1'b0;
        end else begin
            cpuRdValid_r <= (sel_s == SEL_CPU) && !bus.cpuWe_I;
            dbgRdValid_r <= (sel_s == SEL_DBG) && !bus.dbgWe_I;
            if ((sel_s == SEL_CPU) && !bus.cpuWe_I) begin
                cpuRdData_r <= bus.memRdData_I;
            end else begin
                cpuRdData_r <= cpuRdData_r;
            end
            if ((sel_s == SEL_DBG) && !bus.dbgWe_I) begin
                dbgRdData_r <= bus.memRdData_I;
            end else begin
                dbgRdData_r <= dbgRdData_r;
            end
        end
    end

    assign bus.cpuGnt_O     = cpuGnt_s;
    assign bus.dbgGnt_O     = dbgGnt_s;
    assign bus.cpuStall_O   = bus.cpuReq_I & ~cpuGnt_s;
    assign bus.cpuRdData_O  = cpuRdData_r;
    assign bus.dbgRdData_O  = dbgRdData_r;
    assign bus.cpuRdValid_O = cpuRdValid_r;
    assign bus.dbgRdValid_O = dbgRdValid_r;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline's MEM stage and a debug/loader port, so programs and data can be loaded or inspected while the core runs. Conflicts are resolved cycle by cycle: the CPU normally wins, and a starvation counter guarantees the debug port an access within `MAX_WAIT` lost cycles. A losing CPU access raises a stall that freezes the PC and the IF/ID, ID/EX and EX/MEM registers. Read data returns one cycle after grant on the winning port only.

## Interface
- `ADDR_W`, 32, address width of both requesters and the memory side.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 4, consecutive lost debug cycles before debug takes priority; legal range 1..15.

Ports:
- `clk_I`  in  1  single clock, all state on rising edge.
- `reset_I`  in  1  asynchronous, active-low reset.
- `cpuReq_I`  in  1  MEM stage access valid (MEM_memReadEnable | MEM_memWriteEn).
- `cpuWe_I`  in  1  1 = store, 0 = load.
- `cpuAddr_I`  in  ADDR_W  byte address.
- `cpuWrData_I`  in  DATA_W  store data.
- `cpuFunc3_I`  in  3  load/store width and sign.
- `cpuGnt_O`  out  1  CPU access issued this cycle (combinational).
- `cpuStall_O`  out  1  cpuReq_I & ~cpuGnt_O.
- `cpuRdData_O`  out  DATA_W  registered load data.
- `cpuRdValid_O`  out  1  cpuRdData_O valid (one-cycle pulse).
- `dbgReq_I`, `dbgWe_I`, `dbgAddr_I`, `dbgWrData_I`  in  1/1/ADDR_W/DATA_W  debug request; always word access.
- `dbgGnt_O`  out  1  debug access issued this cycle (combinational).
- `dbgRdData_O`  out  DATA_W  registered debug read data.
- `dbgRdValid_O`  out  1  one-cycle pulse.
- `memAddr_O`, `memWrData_O`, `memFunc3_O`  out  ADDR_W/DATA_W/3  muxed from the winner; zero when idle.
- `memWriteEn_O`, `memReadEnable_O`  out  1  asserted only in a grant cycle.
- `memRdData_I`  in  DATA_W  combinational read data from the memory.

## Operation
- Each requester holds its request fields stable until it sees its grant.
- A grant issues the access to the memory in the same cycle. The memory writes on the next rising edge.
- FSM, 2 states:
  - `CPU_PRI` (reset state): CPU wins conflicts. `waitCnt` increments each cycle `dbgReq_I & ~dbgGnt_O`. When `waitCnt == MAX_WAIT-1` and debug loses again, go to `DBG_PRI`.
  - `DBG_PRI`: debug wins conflicts. Return to `CPU_PRI` after one debug grant, or immediately if `dbgReq_I` is low.
- `waitCnt` clears on any debug grant, on `dbgReq_I` low, and on entry to `CPU_PRI`. It is 4 bits and saturates; it never wraps.
- A single requester with no competitor is always granted, in either state.
- On a read grant, `memRdData_I` is captured into the winner's RdData register. The winner's RdValid pulses in the following cycle.
- A write grant produces no RdValid.
- `memFunc3_O` = `cpuFunc3_I` on a CPU grant. It is 3'b010 on a debug grant.

## Timing
- Reset values: state `CPU_PRI`, `waitCnt` 0, both RdData 0, both RdValid 0.
- While reset is asserted, grants and mem enables are forced 0.
- Grant latency is 0 cycles when uncontended. Read latency is 1 cycle, grant to RdValid.
- Worst-case debug wait is `MAX_WAIT` cycles under continuous CPU requests.
- CPU stall is at most 1 cycle per debug access.
- When both request in the same cycle, exactly one grant is asserted; grants are never simultaneous.
- `memReadEnable_O` and `memWriteEn_O` are mutually exclusive.
- Reset asserted mid-access: the pending RdValid is suppressed. A write issued on the edge coinciding with reset assertion is not guaranteed.
- RdData holds its value until that port's next read grant.

## Structure
- Shared package `dmem_arb_pkg`:
  - state encoding `CPU_PRI = 1'b0`, `DBG_PRI = 1'b1`;
  - constant `FUNC3_WORD = 3'b010`;
  - port-select encoding.
- No sub-module. The arbiter FSM, counter and return registers are one block.
- The instantiation replaces the direct `dataMem` hookup.
- `cpuStall_O` is ORed into the hazard detector's enable-low paths.

## Test plan
1. CPU-only traffic:
   - Stimulus: CPU stores 0xDEADBEEF to address 0x10, then loads word from 0x10.
   - Required: a grant every cycle, `cpuStall_O` never set, `cpuRdValid_O` one cycle after the load, `cpuRdData_O` = 0xDEADBEEF.
2. Debug-only traffic:
   - Stimulus: debug writes 0x12345678 to address 0x20, then reads it.
   - Required: `memFunc3_O` = 010, `dbgRdData_O` = 0x12345678 one cycle after the read grant.
3. Starvation with `MAX_WAIT` = 4:
   - Stimulus: CPU requests continuously, debug requests from cycle 0.
   - Required: debug loses cycles 0–3 and is granted in cycle 4; `cpuStall_O` = 1 only in cycle 4; state returns to `CPU_PRI` in cycle 5.
4. Debug request drops while in `DBG_PRI`:
   - Stimulus: as scenario 3, but deassert `dbgReq_I` in the cycle after the FSM enters `DBG_PRI`, before any debug grant.
   - Required: FSM returns to `CPU_PRI`, `waitCnt` = 0, no debug grant.
5. Reset during a read:
   - Stimulus: assert reset in the cycle after a CPU read grant.
   - Required: `cpuRdValid_O` stays 0; all outputs reach their reset values with no clock edge.
6. Concurrent grant check:
   - Stimulus: random requests from both ports for 10k cycles.
   - Required: never both grants high; the debug grant gap never exceeds `MAX_WAIT`; scoreboard matches all read data.
